sd_sample_requester: RTL and testbench

//  Initiator side of the sys_cmd/sys_arg1/sys_reqId request channel and consumer of the hOp/hData/hReqId

---
 rtl/sd_sample_requester.sv | 186 ++++++++++++++++++
 tb/tb_sd_sample_requester.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sample_requester.sv
// rtl/sd_sample_requester.sv - streams WAV samples from the SD controller one read-at-position per sample
// Issues cmd 3 per sample, buffers returned words in a FIFO, closes the file with cmd 4.
module sd_sample_requester #(
    parameter int FILESIZE_WIDTH = 25,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                    sd_clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [FILESIZE_WIDTH:0] file_len,
    input  logic [15:0]             hOp,
    input  logic [31:0]             hData,
    input  logic [15:0]             hReqId,
    output logic [7:0]              sys_cmd,
    output logic [FILESIZE_WIDTH:0] sys_arg1,
    output logic [3:0]              sys_reqId,
    input  logic                    sample_rd,
    output logic [31:0]             sample_data,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int PW = FILESIZE_WIDTH + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT       = 3'd2;
    localparam logic [2:0] S_CLOSE      = 3'd3;
    localparam logic [2:0] S_CLOSE_WAIT = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_ERR        = 3'd6;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [PW-1:0] pos;
    logic [PW-1:0] fileLen;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [1:0]    rspPrev;
    logic          rspLoaded;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;

    logic          rspEvent;
    logic          pushEn;
    logic          popEn;
    logic          startAcc;
    logic          timeoutHit;
    logic [RW-1:0] retryNext;
    logic          retryOk;
    logic          lastSample;

    wire unusedBits = &{1'b0, hOp[15:4], hReqId[15:2]};

    // A response is any change of the low reqId bits; the first cycle after reset only captures them.
    assign rspEvent   = rspLoaded && (hReqId[1:0] != rspPrev);
    assign pushEn     = (state == S_WAIT) && rspEvent && (hOp[3:0] == 4'd5);
    assign popEn      = sample_rd && (count != '0);
    assign startAcc   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign timeoutHit = (timer == TIMER_LAST);
    assign retryNext  = retry + RW'(1);
    assign retryOk    = retryNext < RW'(MAX_RETRY);
    assign lastSample = (pos == (fileLen - PW'(1)));

    assign sample_data  = mem[rdPtr];
    assign sample_valid = (count != '0);
    assign busy         = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    always_ff @(posedge sd_clk) begin
        if (pushEn) begin
            mem[wrPtr] <= hData;
        end
    end

    always_ff @(posedge sd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pos       <= '0;
            fileLen   <= '0;
            timer     <= '0;
            retry     <= '0;
            rspPrev   <= 2'b00;
            rspLoaded <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            sys_cmd   <= 8'd0;
            sys_arg1  <= '0;
            sys_reqId <= 4'd0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rspPrev   <= hReqId[1:0];
            rspLoaded <= 1'b1;
            done      <= 1'b0;

            if (startAcc) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (pushEn) wrPtr <= wrPtr + AW'(1);
                if (popEn)  rdPtr <= rdPtr + AW'(1);
                case ({pushEn, popEn})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        pos     <= '0;
                        retry   <= '0;
                        error   <= 1'b0;
                        fileLen <= file_len;
                        state   <= (file_len == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Never request more than the FIFO can hold, so a push can never overflow it.
                    if (count < CW'(FIFO_DEPTH)) begin
                        sys_cmd   <= 8'd3;
                        sys_arg1  <= pos;
                        sys_reqId <= sys_reqId + 4'd1;
                        timer     <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rspEvent && (hOp[3:0] == 4'd5)) begin
                        pos   <= pos + PW'(1);
                        retry <= '0;
                        state <= lastSample ? S_CLOSE : S_ISSUE;
                    end else if (timeoutHit) begin
                        retry <= retryNext;
                        if (retryOk) begin
                            state <= S_ISSUE;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_CLOSE: begin
                    sys_cmd   <= 8'd4;
                    sys_arg1  <= '0;
                    sys_reqId <= sys_reqId + 4'd1;
                    timer     <= '0;
                    state     <= S_CLOSE_WAIT;
                end
                S_CLOSE_WAIT: begin
                    if (rspEvent && (hOp[3:0] == 4'd6)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (timeoutHit) begin
                        retry <= retryNext;
                        if (retryOk) begin
                            state <= S_CLOSE;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sample_requester.sv
// tb/tb_sd_sample_requester.sv - randomized self-checking bench for sd_sample_requester
// The bench plays the host and keeps a queue of the samples the audio path should see.
module tb_sd_sample_requester;
    localparam int FW    = 25;
    localparam int DEPTH = 16;
    localparam int TMO   = 60;

    logic          sd_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [FW:0]   file_len = '0;
    logic [15:0]   hOp = '0;
    logic [31:0]   hData = '0;
    logic [15:0]   hReqId = '0;
    logic [7:0]    sys_cmd;
    logic [FW:0]   sys_arg1;
    logic [3:0]    sys_reqId;
    logic          sample_rd = 1'b0;
    logic [31:0]   sample_data;
    logic          sample_valid;
    logic          busy;
    logic          done;
    logic          error;

    int            totalCnt = 0;
    int            badCnt = 0;
    logic [31:0]   q[$];
    logic [3:0]    expReqId = 4'd0;
    logic [3:0]    lastReqId = 4'd0;
    bit            popEn = 1'b0;

    sd_sample_requester #(
        .FILESIZE_WIDTH(FW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(3)
    ) dut (
        .sd_clk(sd_clk), .reset_n(reset_n), .start(start), .file_len(file_len),
        .hOp(hOp), .hData(hData), .hReqId(hReqId),
        .sys_cmd(sys_cmd), .sys_arg1(sys_arg1), .sys_reqId(sys_reqId),
        .sample_rd(sample_rd), .sample_data(sample_data), .sample_valid(sample_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        if (obs !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; while popping is enabled, randomly consume the FIFO head and check it.
    task automatic cycle();
        logic [31:0] want;
        @(negedge sd_clk);
        sample_rd = 1'b0;
        if (popEn && sample_valid && ($urandom_range(0, 2) == 0)) begin
            if (q.size() == 0) begin
                checkVal("pop_extra", 64'd1, 64'd0);
            end else begin
                want = q.pop_front();
                checkVal("pop_data", sample_data, want);
            end
            sample_rd = 1'b1;
        end
    endtask

    task automatic waitReq(input logic [7:0] expCmd, input logic [FW:0] expArg, input string tag);
        int n = 0;
        while (sys_reqId == lastReqId && n < 300) begin
            cycle();
            n++;
        end
        if (n >= 300) checkVal({tag, "_timeout"}, 64'd0, 64'd1);
        expReqId = expReqId + 4'd1;
        checkVal({tag, "_id"}, sys_reqId, expReqId);
        checkVal({tag, "_cmd"}, sys_cmd, expCmd);
        checkVal({tag, "_arg"}, sys_arg1, expArg);
        lastReqId = sys_reqId;
    endtask

    task automatic respond(input logic [15:0] op, input logic [31:0] data);
        hReqId = hReqId + 16'd1;
        hOp    = op;
        hData  = data;
        if (op[3:0] == 4'd5) q.push_back(data);
    endtask

    task automatic pulseStart(input logic [FW:0] len);
        file_len = len;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic runStream(input int len, input bit randMode);
        logic [31:0] d;
        int n;
        popEn = randMode;
        pulseStart(FW'(len));
        for (int i = 0; i < len; i++) begin
            waitReq(8'd3, (FW+1)'(i), "rd");
            repeat (randMode ? $urandom_range(1, 12) : 10) cycle();
            if (randMode && i == len / 2) begin
                pulseStart(FW'(3));
                checkVal("start_ignored_busy", busy, 1);
            end
            if (randMode && ($urandom_range(0, 3) == 0)) begin
                respond(16'd7, 32'hDEAD0000 | i);
                repeat (3) cycle();
                checkVal("op7_busy", busy, 1);
                checkVal("op7_noreq", sys_reqId, lastReqId);
            end
            if (!randMode && i == 0) checkVal("empty_before", sample_valid, 0);
            d = randMode ? $urandom : (32'hA0 + i);
            respond(16'd5, d);
            if (!randMode && i == 0) begin
                cycle();
                checkVal("latency_valid", sample_valid, 1);
            end
        end
        waitReq(8'd4, '0, "close");
        repeat (4) cycle();
        respond(16'd6, 32'd0);
        n = 0;
        while (!done && n < 50) begin
            cycle();
            n++;
        end
        checkVal("done_pulse", done, 1);
        checkVal("done_busy", busy, 0);
        cycle();
        checkVal("done_once", done, 0);
        popEn = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            cycle();
            n++;
        end
        popEn = 1'b0;
        cycle();
        checkVal("drain_left", q.size(), 0);
        checkVal("drain_empty", sample_valid, 0);
    endtask

    initial begin
        logic [31:0] want;
        int n;
        repeat (3) @(negedge sd_clk);
        checkVal("rst_cmd", sys_cmd, 0);
        checkVal("rst_arg", sys_arg1, 0);
        checkVal("rst_id", sys_reqId, 0);
        checkVal("rst_valid", sample_valid, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_err", error, 0);
        reset_n = 1'b1;
        repeat (2) cycle();

        runStream(4, 1'b0);
        runStream(22, 1'b1);

        // No host answer: three timeouts on position 0, then error.
        pulseStart(FW'(2));
        for (int k = 0; k < 3; k++) waitReq(8'd3, '0, "tmo");
        n = 0;
        while (!error && n < 300) begin
            cycle();
            n++;
        end
        checkVal("tmo_error", error, 1);
        checkVal("tmo_busy", busy, 0);
        checkVal("tmo_noreq", sys_reqId, lastReqId);
        pulseStart('0);
        cycle();
        checkVal("zero_len_err_clr", error, 0);
        checkVal("zero_len_busy", busy, 0);
        checkVal("zero_len_noreq", sys_reqId, lastReqId);

        // FIFO backpressure: exactly DEPTH requests without popping.
        pulseStart(FW'(40));
        for (int i = 0; i < DEPTH; i++) begin
            waitReq(8'd3, (FW+1)'(i), "fill");
            repeat (3) cycle();
            respond(16'd5, $urandom);
        end
        repeat (80) cycle();
        checkVal("stall_noreq", sys_reqId, lastReqId);
        checkVal("stall_valid", sample_valid, 1);
        checkVal("stall_busy", busy, 1);
        want = q.pop_front();
        checkVal("stall_pop", sample_data, want);
        sample_rd = 1'b1;
        waitReq(8'd3, (FW+1)'(DEPTH), "resume");
        repeat (5) cycle();

        reset_n = 1'b0;
        #1;
        checkVal("midrst_valid", sample_valid, 0);
        checkVal("midrst_id", sys_reqId, 0);
        checkVal("midrst_busy", busy, 0);
        checkVal("midrst_cmd", sys_cmd, 0);
        q.delete();
        expReqId = 4'd0;
        lastReqId = 4'd0;
        repeat (2) @(negedge sd_clk);
        reset_n = 1'b1;
        repeat (2) cycle();
        checkVal("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
